multicycle_adder: RTL

MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

---
 rtl/adder_pkg.sv | 7 +
 rtl/multicycle_adder_if.sv | 14 +
 rtl/adder_chunk.sv | 19 +
 rtl/multicycle_adder.sv | 93 +++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared FSM encoding and parameter checks for the chunked adder family.
package adder_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
    function automatic bit width_ok(int width, int chunk);
        return chunk > 0 && width >= chunk && width % chunk == 0;
    endfunction
endpackage

// File: rtl/multicycle_adder_if.sv
// multicycle_adder_if: operand/result handshake bundle for multicycle_adder.
interface multicycle_adder_if #(parameter int WIDTH = 16);
    logic             in_valid, in_ready, Cin, sub;
    logic             out_valid, out_ready, Cout, ovf, zero;
    logic [WIDTH-1:0] A, B, Sum;
    modport master (
        output in_valid, A, B, Cin, sub, out_ready,
        input  in_ready, out_valid, Sum, Cout, ovf, zero
    );
    modport slave (
        input  in_valid, A, B, Cin, sub, out_ready,
        output in_ready, out_valid, Sum, Cout, ovf, zero
    );
endinterface

// File: rtl/adder_chunk.sv
// adder_chunk: purely combinational CHUNK-bit ripple-carry adder.
module adder_chunk #(parameter int CHUNK = 4) (
    input  logic [CHUNK-1:0] A,
    input  logic [CHUNK-1:0] B,
    input  logic             Cin,
    output logic [CHUNK-1:0] Sum,
    output logic             Cout
);
    logic c;
    always_comb begin
        c = Cin;
        Sum = '0;
        for (int k = 0; k < CHUNK; k++) begin
            Sum[k] = A[k] ^ B[k] ^ c;
            c = (A[k] & B[k]) | (c & (A[k] ^ B[k]));
        end
        Cout = c;
    end
endmodule

// File: rtl/multicycle_adder.sv
// multicycle_adder: WIDTH-bit add/subtract computed CHUNK bits per cycle, LSB first.
module multicycle_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    multicycle_adder_if.slave  bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int IW = $clog2(N + 1);

    generate
        if (!width_ok(WIDTH, CHUNK)) begin : g_bad_width
            $error("multicycle_adder: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] a_q, b_q, sum_q, sum_nx, b_eff;
    logic [CHUNK-1:0] a_c, b_c, s_c;
    logic [IW-1:0]    idx;
    logic             carry, c_out, cout_q, ovf_q, zero_q;

    assign b_eff = bus.sub ? ~bus.B : bus.B;

    // Chunk select by comparison keeps the index narrow and avoids a multiplier.
    always_comb begin
        a_c = '0;
        b_c = '0;
        for (int k = 0; k < N; k++)
            if (idx == IW'(k)) begin
                a_c = a_q[k*CHUNK +: CHUNK];
                b_c = b_q[k*CHUNK +: CHUNK];
            end
    end

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
        .A(a_c), .B(b_c), .Cin(carry), .Sum(s_c), .Cout(c_out)
    );

    always_comb begin
        sum_nx = sum_q;
        for (int k = 0; k < N; k++)
            if (idx == IW'(k)) sum_nx[k*CHUNK +: CHUNK] = s_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a_q   <= bus.A;
                    b_q   <= b_eff;
                    carry <= bus.sub | bus.Cin;
                    idx   <= '0;
                    state <= BUSY;
                end
                BUSY: begin
                    sum_q <= sum_nx;
                    carry <= c_out;
                    idx   <= idx + 1'b1;
                    if (idx == IW'(N - 1)) begin
                        state  <= DONE;
                        cout_q <= c_out;
                        ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_nx[WIDTH-1] != a_q[WIDTH-1]);
                        zero_q <= sum_nx == '0;
                    end
                end
                DONE: if (bus.out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.Sum       = sum_q;
    assign bus.Cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule
